// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte request/status handshake of the PS/2 host transmitter.
// The master side offers bytes; the transmitter reports progress back.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic       rx_inhibit;

    modport master (
        output tx_data,
        output tx_start,
        input  tx_busy,
        input  tx_done,
        input  tx_err,
        input  rx_inhibit
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output tx_busy,
        output tx_done,
        output tx_err,
        output rx_inhibit
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter, open-drain line control.
// Define PS2_TX_RESEND_EN to retry a failed byte up to two more times.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 3000,
    parameter int TIMEOUT_CYCLES = 375000,
    parameter int FILTER_LEN     = 8
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_dat_in,
    output logic         ps2_clk_oe,
    output logic         ps2_dat_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    logic [INH_W-1:0] inh_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [3:0]       bit_cnt;
    logic [7:0]       data_q;
    logic             parity_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [1:0]            clk_sync;
    logic [1:0]            dat_sync;
    logic [FILTER_LEN-1:0] clk_sh;
    logic [FILTER_LEN-1:0] dat_sh;
    logic                  clk_f;
    logic                  dat_f;
    logic                  fall;

    logic accept;
    logic tmo_hit;
    logic nack;
    logic fail;
    logic can_retry;

    assign tx.tx_busy    = busy_q;
    assign tx.tx_done    = done_q;
    assign tx.tx_err     = err_q;
    assign tx.rx_inhibit = busy_q;

    // Idle bus is high, so the conditioning chain resets to 1s.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_sh   <= '1;
            dat_sh   <= '1;
            clk_f    <= 1'b1;
            dat_f    <= 1'b1;
            fall     <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
            clk_sh   <= {clk_sh[FILTER_LEN-2:0], clk_sync[1]};
            dat_sh   <= {dat_sh[FILTER_LEN-2:0], dat_sync[1]};
            if (&clk_sh) begin
                clk_f <= 1'b1;
            end else if (~|clk_sh) begin
                clk_f <= 1'b0;
            end
            if (&dat_sh) begin
                dat_f <= 1'b1;
            end else if (~|dat_sh) begin
                dat_f <= 1'b0;
            end
            fall <= clk_f & ~|clk_sh;
        end
    end

    always_comb begin
        accept  = (state == S_IDLE) && tx.tx_start;
        tmo_hit = ((state == S_SHIFT) || (state == S_WAIT_IDLE))
                  && (tmo_cnt == TMO_LAST);
        nack    = (state == S_SHIFT) && fall
                  && (bit_cnt == 4'd10) && dat_f;
        fail    = tmo_hit || nack;
    end

`ifdef PS2_TX_RESEND_EN
    logic [1:0] retry_cnt;

    assign can_retry = (retry_cnt != 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt <= 2'd0;
        end else if (accept) begin
            retry_cnt <= 2'd0;
        end else if (fail && can_retry) begin
            retry_cnt <= retry_cnt + 2'd1;
        end
    end
`else
    assign can_retry = 1'b0;
`endif

    // A failure (timeout wins over a coincident fall) preempts the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            inh_cnt    <= '0;
            tmo_cnt    <= '0;
            bit_cnt    <= '0;
            data_q     <= '0;
            parity_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else if (fail) begin
            ps2_dat_oe <= 1'b0;
            if (can_retry) begin
                ps2_clk_oe <= 1'b1;
                inh_cnt    <= '0;
                state      <= S_INHIBIT;
            end else begin
                ps2_clk_oe <= 1'b0;
                err_q      <= 1'b1;
                state      <= S_ERR;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (tx.tx_start) begin
                        data_q     <= tx.tx_data;
                        parity_q   <= ~^tx.tx_data;
                        inh_cnt    <= '0;
                        busy_q     <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        state      <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (inh_cnt == INH_LAST) begin
                        ps2_dat_oe <= 1'b1;
                        state      <= S_REQ;
                    end else begin
                        inh_cnt <= inh_cnt + INH_W'(1);
                    end
                end
                S_REQ: begin
                    ps2_clk_oe <= 1'b0;
                    bit_cnt    <= '0;
                    tmo_cnt    <= '0;
                    state      <= S_SHIFT;
                end
                S_SHIFT: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        unique case (1'b1)
                            (bit_cnt < 4'd8):
                                ps2_dat_oe <= ~data_q[bit_cnt[2:0]];
                            (bit_cnt == 4'd8):
                                ps2_dat_oe <= ~parity_q;
                            (bit_cnt == 4'd9):
                                ps2_dat_oe <= 1'b0;
                            (bit_cnt == 4'd10):
                                state <= S_WAIT_IDLE;
                            default: ;
                        endcase
                    end
                end
                S_WAIT_IDLE: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (clk_f && dat_f) begin
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                S_ERR: begin
                    err_q      <= 1'b0;
                    busy_q     <= 1'b0;
                    ps2_clk_oe <= 1'b0;
                    ps2_dat_oe <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench with a bus-level PS/2 device model.
// Frames seen on the wire are compared against start/data/odd-parity/stop.
module tb_ps2_host_tx;

    localparam int INH = 50;
    localparam int TMO = 1000;
    localparam int FL  = 8;
    localparam int H   = 20;
`ifdef PS2_TX_RESEND_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    logic ps2_clk_oe;
    logic ps2_dat_oe;
    logic ps2_clk_in;
    logic ps2_dat_in;

    always #5 clk = ~clk;

    assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
    assign ps2_dat_in = ~ps2_dat_oe & dev_dat;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN(FL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx(bus),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_dat_oe(ps2_dat_oe)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    // Per-cycle observer of pulses, inhibit length and release timing.
    int n_done = 0;
    int n_err = 0;
    int n_inh = 0;
    int inh_run = 0;
    int inh_len = 0;
    int req_run = 0;
    int req_len = 0;
    int rel_cyc = 0;
    int err_cyc = 0;
    logic p_clk_oe = 1'b0;
    logic p_done = 1'b0;
    logic p_err = 1'b0;

    always @(negedge clk) begin
        check("inhibit_eq_busy", 32'(bus.rx_inhibit), 32'(bus.tx_busy));
        check("done_err_excl", 32'(bus.tx_done & bus.tx_err), 0);
        check("done_width", 32'(bus.tx_done & p_done), 0);
        check("err_width", 32'(bus.tx_err & p_err), 0);
        if (!bus.tx_busy)
            check("idle_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
        if (bus.tx_done) n_done++;
        if (bus.tx_err) begin
            n_err++;
            err_cyc = cyc;
        end
        if (ps2_clk_oe && !ps2_dat_oe) begin
            inh_run++;
            req_run = 0;
        end else if (ps2_clk_oe && ps2_dat_oe) begin
            if (inh_run != 0) begin
                inh_len = inh_run;
                n_inh++;
            end
            inh_run = 0;
            req_run++;
        end else begin
            if (p_clk_oe) begin
                req_len = req_run;
                rel_cyc = cyc;
            end
            inh_run = 0;
            req_run = 0;
        end
        p_clk_oe = ps2_clk_oe;
        p_done = bus.tx_done;
        p_err = bus.tx_err;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        bus.tx_data = d;
        bus.tx_start = 1'b1;
        tick();
        bus.tx_start = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int lim);
        for (int i = 0; i < lim && bus.tx_busy; i++) tick();
        check(nm, 32'(bus.tx_busy), 0);
    endtask

    // Device: waits for request-to-send, clocks npulse bits, samples on rise.
    task automatic device(input int npulse, input bit ack, input int glitch_at,
                          output logic [10:0] fr, output bit ok);
        fr = '0;
        ok = 1'b0;
        for (int i = 0; i < INH + 200 && !(ps2_dat_oe && !ps2_clk_oe); i++)
            tick();
        if (!(ps2_dat_oe && !ps2_clk_oe)) return;
        ok = 1'b1;
        repeat (H) tick();
        fr[0] = ps2_dat_in;
        for (int k = 1; k <= npulse; k++) begin
            if (k == 11) begin
                dev_dat = ~ack;
                repeat (H) tick();
            end
            dev_clk = 1'b0;
            repeat (H) tick();
            dev_clk = 1'b1;
            if (k <= 10) fr[k] = ps2_dat_in;
            repeat (H) tick();
            if (k == glitch_at) begin
                dev_clk = 1'b0;
                repeat (3) tick();
                dev_clk = 1'b1;
                repeat (H) tick();
            end
        end
        dev_dat = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] fr;
        bit ok;
        int d0, e0, i0;

        bus.tx_data = 8'h00;
        bus.tx_start = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
        check("rst_flags", {29'd0, bus.tx_busy, bus.tx_done, bus.tx_err}, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        // 0xED set-LEDs, acknowledged
        d0 = n_done;
        e0 = n_err;
        send(8'hED);
        check("ed_busy_rise", 32'(bus.tx_busy), 1);
        device(11, 1'b1, 0, fr, ok);
        check("ed_req", 32'(ok), 1);
        check("ed_frame_lit", 32'(fr), 32'h7DA);
        check("ed_frame_model", 32'(fr), 32'(frame_of(8'hED)));
        wait_idle("ed_idle", 300);
        check("ed_done", n_done - d0, 1);
        check("ed_noerr", n_err - e0, 0);

        // 0x00: parity 1, inhibit length, one-cycle request
        repeat (5) tick();
        d0 = n_done;
        send(8'h00);
        device(11, 1'b1, 0, fr, ok);
        check("z_req", 32'(ok), 1);
        check("z_frame_lit", 32'(fr), 32'h600);
        check("z_inh_len", inh_len, INH);
        check("z_req_len", req_len, 1);
        wait_idle("z_idle", 300);
        check("z_done", n_done - d0, 1);

        // 0xFF refused by device (NACK)
        repeat (5) tick();
        d0 = n_done;
        e0 = n_err;
        i0 = n_inh;
        send(8'hFF);
        for (int a = 0; a < ATTEMPTS; a++) begin
            device(11, 1'b0, 0, fr, ok);
            check("nack_req", 32'(ok), 1);
            check("nack_frame", 32'(fr), 32'(frame_of(8'hFF)));
        end
        wait_idle("nack_idle", 300);
        check("nack_err", n_err - e0, 1);
        check("nack_nodone", n_done - d0, 0);
        check("nack_inh", n_inh - i0, ATTEMPTS);
        @(negedge clk);
        check("nack_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);

        // Device never clocks: timeout after release
        repeat (5) tick();
        d0 = n_done;
        e0 = n_err;
        send(8'h3C);
        wait_idle("tmo_idle", ATTEMPTS * (INH + TMO + 20));
        check("tmo_err", n_err - e0, 1);
        check("tmo_nodone", n_done - d0, 0);
        check("tmo_delay", err_cyc - rel_cyc, TMO);
        @(negedge clk);
        check("tmo_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);

        // Reset after four bits shifted
        repeat (5) tick();
        d0 = n_done;
        e0 = n_err;
        send(8'h55);
        device(4, 1'b1, 0, fr, ok);
        check("rst_mid_req", 32'(ok), 1);
        check("rst_mid_busy", 32'(bus.tx_busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_lines", {30'd0, ps2_clk_oe, ps2_dat_oe}, 0);
        check("rst_mid_busy0", 32'(bus.tx_busy), 0);
        repeat (30) tick();
        check("rst_mid_nopulse", (n_done - d0) + (n_err - e0), 0);
        send(8'hF4);
        device(11, 1'b1, 0, fr, ok);
        check("f4_frame", 32'(fr), 32'(frame_of(8'hF4)));
        wait_idle("f4_idle", 300);
        check("f4_done", n_done - d0, 1);

        // Glitch on clock plus an ignored second request
        repeat (5) tick();
        d0 = n_done;
        e0 = n_err;
        send(8'hA5);
        repeat (4) tick();
        send(8'h12);
        device(11, 1'b1, 3, fr, ok);
        check("gl_req", 32'(ok), 1);
        check("gl_frame_lit", 32'(fr), 32'h74A);
        check("gl_frame_model", 32'(fr), 32'(frame_of(8'hA5)));
        wait_idle("gl_idle", 300);
        check("gl_done", n_done - d0, 1);
        check("gl_noerr", n_err - e0, 0);
        repeat (20) tick();
        check("gl_no_second", n_done - d0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
